// File: rtl/bus_trace_if.sv
// Bus/trace bundle for bus_trace. The trace_data width grows to 40 bits
// when BUS_TRACE_TIMESTAMP_EN is defined.
interface bus_trace_if;
`ifdef BUS_TRACE_TIMESTAMP_EN
    localparam int REC_W = 40;
`else
    localparam int REC_W = 24;
`endif

    logic [3:0]       data_i;
    logic             sync;
    // Handshake: trace_valid stays high while an entry is held, trace_data is
    // stable while valid, and an entry transfers on a clock where valid && ready.
    logic             trace_valid;
    logic             trace_ready;
    logic [REC_W-1:0] trace_data;

    modport master (input data_i, sync, trace_ready, output trace_valid, trace_data);
    modport slave  (output data_i, sync, trace_ready, input trace_valid, trace_data);
endinterface

// File: rtl/bus_trace.sv
// Passive 4-bit bus monitor: rebuilds {addr, opcode, x2} per instruction cycle
// into a FIFO. Optional macro BUS_TRACE_TIMESTAMP_EN adds a 16-bit A1 timestamp.
module bus_trace #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3   // log2(DEPTH)
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        halt,
    input  logic        enable,
    input  logic        clear_status,
    bus_trace_if.master bus,
    output logic        overflow,
    output logic        resync_err,
    output logic [7:0]  drop_count,
    output logic [3:0]  phase_dbg
);
`ifdef BUS_TRACE_TIMESTAMP_EN
    localparam int REC_W = 40;
`else
    localparam int REC_W = 24;
`endif

    typedef enum logic [3:0] {
        S_IDLE, S_A1, S_A2, S_A3, S_M1, S_M2, S_X1, S_X2, S_X3, S_WAIT
    } phase_t;

    phase_t state, state_nxt;
    logic   resync_ev, push_req;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!halt) begin
            case (state)
                S_IDLE:         state_nxt = bus.sync ? S_A1 : S_IDLE;
                S_A1:           state_nxt = bus.sync ? S_A1 : S_A2;
                S_A2:           state_nxt = bus.sync ? S_A1 : S_A3;
                S_A3:           state_nxt = bus.sync ? S_A1 : S_M1;
                S_M1:           state_nxt = bus.sync ? S_A1 : S_M2;
                S_M2:           state_nxt = bus.sync ? S_A1 : S_X1;
                S_X1:           state_nxt = bus.sync ? S_A1 : S_X2;
                S_X2:           state_nxt = bus.sync ? S_A1 : S_X3;
                S_X3, S_WAIT:   state_nxt = bus.sync ? S_A1 : S_WAIT;
                default:        state_nxt = S_IDLE;
            endcase
        end
    end

    // A sync inside A1..X2 aborts the partial record, so X2 only pushes without sync.
    always_comb begin
        resync_ev = 1'b0;
        push_req  = 1'b0;
        if (!halt) begin
            resync_ev = bus.sync && (state >= S_A1) && (state <= S_X2);
            push_req  = (state == S_X2) && !bus.sync && enable;
        end
    end

    assign phase_dbg = state;

    logic [11:0] addr_q;
    logic [7:0]  op_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            addr_q <= '0;
            op_q   <= '0;
        end else if (!halt) begin
            case (state)
                S_A1:    addr_q[3:0]  <= bus.data_i;
                S_A2:    addr_q[7:4]  <= bus.data_i;
                S_A3:    addr_q[11:8] <= bus.data_i;
                S_M1:    op_q[7:4]    <= bus.data_i;
                S_M2:    op_q[3:0]    <= bus.data_i;
                default: ;
            endcase
        end
    end

    logic [REC_W-1:0] record;
`ifdef BUS_TRACE_TIMESTAMP_EN
    logic [15:0] ts_cnt, ts_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ts_cnt <= '0;
            ts_q   <= '0;
        end else if (!halt) begin
            if (state_nxt == S_A1) ts_cnt <= ts_cnt + 16'd1;
            if (state == S_A1)     ts_q   <= ts_cnt;
        end
    end
    assign record = {ts_q, addr_q, op_q, bus.data_i};
`else
    assign record = {addr_q, op_q, bus.data_i};
`endif

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [PTR_W:0]   wr_ptr, rd_ptr;
    logic [REC_W-1:0] mem [DEPTH];
    logic             empty, full, pop, push_ok, drop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop     = !empty && bus.trace_ready;
    assign push_ok = push_req && (!full || pop);
    assign drop    = push_req && full && !pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= record;
    end

    assign bus.trace_valid = !empty;
    assign bus.trace_data  = empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

    // A new event in the same clock as clear_status wins over the clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overflow   <= 1'b0;
            resync_err <= 1'b0;
            drop_count <= '0;
        end else begin
            if (drop)              overflow <= 1'b1;
            else if (clear_status) overflow <= 1'b0;

            if (resync_ev)         resync_err <= 1'b1;
            else if (clear_status) resync_err <= 1'b0;

            if (drop) begin
                if (clear_status)              drop_count <= 8'd1;
                else if (drop_count != 8'hFF)  drop_count <= drop_count + 8'd1;
            end else if (clear_status) begin
                drop_count <= '0;
            end
        end
    end
endmodule
